// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decoder state encoding and default key table.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Set-2 make codes for the default table (slot 0 .. slot 3)
    localparam logic [7:0] CODE_A = 8'h1C;
    localparam logic [7:0] CODE_B = 8'h32;
    localparam logic [7:0] CODE_C = 8'h21;
    localparam logic [7:0] CODE_D = 8'h23;

    localparam logic [31:0] DEFAULT_KEY_CODES = {CODE_D, CODE_C, CODE_B, CODE_A};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    // Prefix bytes are protocol framing and can never select a key slot.
    function automatic logic is_prefix(input logic [7:0] code);
        return (code == BREAK_CODE) || (code == EXT_CODE);
    endfunction

endpackage

// File: rtl/ps2_key_indicator_if.sv
// Byte input from the PS/2 receiver and the indicator/event outputs.
interface ps2_key_indicator_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [7:0]          scan_code;
    logic                scan_code_ready;
    logic [NUM_KEYS-1:0] led;
    logic                key_event;
    logic [3:0]          key_index;
    logic                key_release;
    logic                unknown_code;

    // Byte source / event consumer side
    modport master (
        output scan_code, scan_code_ready,
        input  led, key_event, key_index, key_release, unknown_code
    );

    // Indicator block side
    modport slave (
        input  scan_code, scan_code_ready,
        output led, key_event, key_index, key_release, unknown_code
    );
endinterface

// File: rtl/ps2_code_match.sv
// Combinational lookup of a scan code in the packed make-code table.
// Lowest matching slot wins; prefix bytes never match.
module ps2_code_match
    import ps2_pkg::*;
#(
    parameter int unsigned            NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*8-1:0]  KEY_CODES = DEFAULT_KEY_CODES
) (
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] index
);

    logic [NUM_KEYS-1:0] match;

    // Compare the byte against every slot in parallel
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            match[i] = (code == KEY_CODES[8*i +: 8]) && !is_prefix(code);
        end
    end

    // Priority-encode the match vector, lowest slot first
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!hit && match[i]) begin
                hit   = 1'b1;
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_indicator.sv
// PS/2 key indicator: decodes make/break/extended byte sequences, tracks
// which table keys are held and drives one LED per slot plus event pulses.
module ps2_key_indicator
    import ps2_pkg::*;
#(
    parameter int unsigned            NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]  KEY_CODES      = DEFAULT_KEY_CODES,
    parameter int unsigned            TOGGLE_MODE    = 0,
    parameter int unsigned            PREFIX_TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_indicator_if.slave bus
);

    localparam int unsigned          CNT_W        = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    ps2_state_t          state, state_nxt;
    logic [CNT_W-1:0]    idle_cnt, idle_cnt_nxt;
    logic                byte_make, byte_break;

    logic                hit;
    logic [3:0]          hit_index;
    logic [NUM_KEYS-1:0] hit_oh;
    logic                held_hit;

    logic [NUM_KEYS-1:0] held, held_nxt;
    logic [NUM_KEYS-1:0] led_q, led_nxt;
    logic                key_event_q, key_event_nxt;
    logic [3:0]          key_index_q, key_index_nxt;
    logic                key_release_q, key_release_nxt;
    logic                unknown_q, unknown_nxt;

    ps2_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .code  (bus.scan_code),
        .hit   (hit),
        .index (hit_index)
    );

    // Expand the matched slot to a one-hot mask for held/led updates
    always_comb begin
        hit_oh = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hit_oh[i] = hit && (hit_index == 4'(i));
        end
    end

    assign held_hit = |(held & hit_oh);

    // Next-state, prefix timeout and byte classification
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        byte_make    = 1'b0;
        byte_break   = 1'b0;

        if (bus.scan_code_ready) begin
            // A strobe always wins over a coinciding timeout.
            idle_cnt_nxt = '0;
            case (state)
                ST_IDLE: begin
                    if (bus.scan_code == BREAK_CODE) begin
                        state_nxt = ST_BRK;
                    end else if (bus.scan_code == EXT_CODE) begin
                        state_nxt = ST_EXT;
                    end else begin
                        byte_make = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_nxt  = ST_IDLE;
                    byte_break = 1'b1;
                end
                ST_EXT: begin
                    state_nxt = (bus.scan_code == BREAK_CODE) ? ST_EXT_BRK : ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE) begin
            if (idle_cnt == TIMEOUT_LAST) begin
                state_nxt    = ST_IDLE;
                idle_cnt_nxt = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt_nxt = '0;
        end
    end

    // Held-key tracking, LED update and event outputs
    always_comb begin
        held_nxt        = held;
        led_nxt         = led_q;
        key_event_nxt   = 1'b0;
        key_index_nxt   = key_index_q;
        key_release_nxt = key_release_q;
        unknown_nxt     = 1'b0;

        if (byte_make) begin
            if (!hit) begin
                unknown_nxt = 1'b1;
            end else if (!held_hit) begin
                held_nxt        = held | hit_oh;
                key_event_nxt   = 1'b1;
                key_index_nxt   = hit_index;
                key_release_nxt = 1'b0;
                if (TOGGLE_MODE != 0) begin
                    led_nxt = led_q ^ hit_oh;
                end
            end
        end else if (byte_break && held_hit) begin
            held_nxt        = held & ~hit_oh;
            key_event_nxt   = 1'b1;
            key_index_nxt   = hit_index;
            key_release_nxt = 1'b1;
        end

        if (TOGGLE_MODE == 0) begin
            led_nxt = held_nxt;
        end
    end

    // Decoder state and prefix idle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Registered key state and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held          <= '0;
            led_q         <= '0;
            key_event_q   <= 1'b0;
            key_index_q   <= '0;
            key_release_q <= 1'b0;
            unknown_q     <= 1'b0;
        end else begin
            held          <= held_nxt;
            led_q         <= led_nxt;
            key_event_q   <= key_event_nxt;
            key_index_q   <= key_index_nxt;
            key_release_q <= key_release_nxt;
            unknown_q     <= unknown_nxt;
        end
    end

    assign bus.led          = led_q;
    assign bus.key_event    = key_event_q;
    assign bus.key_index    = key_index_q;
    assign bus.key_release  = key_release_q;
    assign bus.unknown_code = unknown_q;

endmodule

// File: doc/ps2_key_indicator.md
PS2_KEY_INDICATOR -- requirements
Module: ps2_key_indicator

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of tracked keys/LEDs (legal 1..16).
REQ-002 SHALL have parameter KEY_CODES, default {8'h23,8'h21,8'h32,8'h1C}, NUM_KEYS*8-bit packed make-code table; slot i = bits [8i+7:8i] (default slots 0..3 = A,B,C,D).
REQ-003 SHALL have parameter TOGGLE_MODE, default 0; 0 = LED follows key held, 1 = LED toggles on each fresh press.
REQ-004 SHALL have parameter PREFIX_TIMEOUT, default 1_000_000, clock cycles a prefix state may wait for its next byte.
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port scan_code  input  8  byte from PS/2 receiver, valid when scan_code_ready high.
REQ-008 SHALL have port scan_code_ready  input  1  one-cycle strobe, one byte per strobe.
REQ-009 SHALL have port led  output  NUM_KEYS  indicator per table slot.
REQ-010 SHALL have port key_event  output  1  one-cycle pulse on accepted press or release of a table key.
REQ-011 SHALL have port key_index  output  4  slot of last event; held until next event.
REQ-012 SHALL have port key_release  output  1  1 = last event was release; held with key_index.
REQ-013 SHALL have port unknown_code  output  1  one-cycle pulse when a non-extended make code matches no slot.

Function
REQ-014 SHALL run FSM states IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
REQ-015 SHALL transition on strobe: IDLE+F0->BRK; IDLE+E0->EXT; EXT+F0->EXT_BRK; any other byte in any state->IDLE after processing.
REQ-016 SHALL treat byte in IDLE as make, in BRK as break, in EXT/EXT_BRK as extended and discard it (no event, no unknown_code).
REQ-017 SHALL match by comparing byte with all slots in parallel; on duplicate entries lowest index wins; F0/E0 never match.
REQ-018 SHALL keep internal held[NUM_KEYS]: make on matched slot sets bit, break clears it.
REQ-019 SHALL treat make on already-held slot (typematic repeat) as no event and no LED change.
REQ-020 SHALL treat break on non-held slot as no event.
REQ-021 SHALL drive led = held when TOGGLE_MODE=0; when 1, led bit inverts on each accepted press event and ignores releases.
REQ-022 SHALL register all outputs: byte strobed in cycle t gives led/key_event/key_index/key_release/unknown_code update visible after edge t+1 (latency 1).
REQ-023 SHALL count idle cycles in BRK/EXT/EXT_BRK; at PREFIX_TIMEOUT with no strobe return to IDLE with no event; counter clears on every strobe and in IDLE.
REQ-024 SHALL, if strobe and timeout coincide, process the byte in current state and ignore the timeout.
REQ-025 SHALL drop unknown break codes silently (unknown_code only for makes).

Reset
REQ-026 SHALL, on reset low, asynchronously force FSM IDLE, timeout counter 0, held 0, led 0, key_event 0, key_index 0, key_release 0, unknown_code 0.
REQ-027 SHALL abandon any pending prefix on reset mid-sequence; first byte after release is decoded from IDLE.

Structure
REQ-028 SHALL take codes 8'hF0 (break) and 8'hE0 (extended), FSM state encoding and default A-D make codes from shared package ps2_pkg.
REQ-029 SHALL place table lookup in sub-module ps2_code_match (byte in, hit and index out, combinational, parametrised by NUM_KEYS/KEY_CODES).
REQ-030 SHALL size timeout counter as $clog2(PREFIX_TIMEOUT+1) bits.

Verification
REQ-031 SHALL cover default params, strobe 1C -> next cycle led=0001, key_event pulse, key_index=0, key_release=0; then F0,1C -> led=0000, key_release=1.
REQ-032 SHALL cover 32,32,32 repeat -> one key_event only, led=0010; F0,32 -> led=0000.
REQ-033 SHALL cover TOGGLE_MODE=1: 21,F0,21,21,F0,21 -> led[2] 1 then 0, two press events, releases produce no LED change.
REQ-034 SHALL cover E0,1C and E0,F0,1C -> no event, led unchanged; 5A -> unknown_code pulse, led unchanged.
REQ-035 SHALL cover PREFIX_TIMEOUT=8: F0 then 8 idle cycles then 23 -> treated as make, led=1000; reset low after F0 then 23 -> make.
REQ-036 SHALL cover NUM_KEYS=8 with duplicate code 8'h1C at slots 2 and 5 -> key_index=2.
